// File: rtl/rotary_entry_sequencer_pkg.sv
// Shared widths and state encodings for the rotary-encoder operand entry sequencer.
// The raw encodings are the values seen on the state port and on the LEDs.
package rotary_pkg;

  localparam int OPW  = 7;
  localparam int SUMW = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_L1HI = 3'd1;
  localparam logic [2:0] ST_L1LO = 3'd2;
  localparam logic [2:0] ST_L2HI = 3'd3;
  localparam logic [2:0] ST_L2LO = 3'd4;
  localparam logic [2:0] ST_LCIN = 3'd5;
  localparam logic [2:0] ST_SHOW = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_L1HI = ST_L1HI,
    S_L1LO = ST_L1LO,
    S_L2HI = ST_L2HI,
    S_L2LO = ST_L2LO,
    S_LCIN = ST_LCIN,
    S_SHOW = ST_SHOW
  } state_e;

endpackage

// File: rtl/rotary_entry_sequencer_if.sv
// Operand/sum bus between the entry sequencer and the external combinational adder.
interface rotary_entry_sequencer_if;
  import rotary_pkg::*;

  logic [OPW-1:0]  num1;
  logic [OPW-1:0]  num2;
  logic            cin;
  logic [SUMW-1:0] sum_in;

  modport master (output num1, output num2, output cin, input sum_in);
  modport slave  (input num1, input num2, input cin, output sum_in);
endinterface

// File: rtl/rotary_entry_sequencer_quad_step_detect.sv
// Quadrature-to-step converter: synchronizes the encoder phases and emits one
// forward or back pulse per detent, taken on the rising edge of the 11 "event".
module quad_step_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic FWD_DIR     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rot_a,
  input  logic rot_b,
  output logic step_fwd,
  output logic step_back
);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic evt_q, evt_d;
  logic dir_q, dir_d;
  logic prev_evt_q, prev_evt_d;
  logic a_s, b_s;
  logic step;

  assign a_s = sync_a_q[SYNC_STAGES-1];
  assign b_s = sync_b_q[SYNC_STAGES-1];

  always_comb begin
    sync_a_d   = {sync_a_q[SYNC_STAGES-2:0], rot_a};
    sync_b_d   = {sync_b_q[SYNC_STAGES-2:0], rot_b};
    evt_d      = evt_q;
    dir_d      = dir_q;
    prev_evt_d = evt_q;
    if (a_s && b_s) begin
      evt_d = 1'b1;
    end else if (!a_s && !b_s) begin
      evt_d = 1'b0;
    end else begin
      // 01 -> direction 1, 10 -> direction 0; the event flag holds through chatter
      dir_d = b_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      evt_q      <= 1'b0;
      dir_q      <= 1'b0;
      prev_evt_q <= 1'b0;
    end else begin
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      evt_q      <= evt_d;
      dir_q      <= dir_d;
      prev_evt_q <= prev_evt_d;
    end
  end

  assign step      = evt_q & ~prev_evt_q;
  assign step_fwd  = step & (dir_q == FWD_DIR);
  assign step_back = step & (dir_q != FWD_DIR);

endmodule

// File: rtl/rotary_entry_sequencer.sv
// Operand entry FSM for the rotary-encoder adder: loads num1/num2/cin from the
// slide switches on forward detents and captures the adder sum in SHOW.
//
// state | meaning
// IDLE  | waiting; next forward step clears operands
// L1HI  | next forward step loads num1[6:4]
// L1LO  | next forward step loads num1[3:0]
// L2HI  | next forward step loads num2[6:4]
// L2LO  | next forward step loads num2[3:0]
// LCIN  | next forward step loads cin
// SHOW  | sum captured once, shown on LEDs
module rotary_entry_sequencer
  import rotary_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic FWD_DIR     = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ROT_A,
  input  logic                             ROT_B,
  input  logic [3:0]                       holder,
  rotary_entry_sequencer_if.master         add_bus,
  output logic [2:0]                       state,
  output logic [SUMW-1:0]                  result_q,
  output logic                             result_valid,
  output logic [7:0]                       led
);

  logic step_fwd, step_back;

  state_e          state_q, state_d;
  logic [OPW-1:0]  num1_q, num1_d;
  logic [OPW-1:0]  num2_q, num2_d;
  logic            cin_q, cin_d;
  logic [SUMW-1:0] result_d;
  logic            result_valid_q, result_valid_d;

  quad_step_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .FWD_DIR     (FWD_DIR)
  ) u_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .rot_a     (ROT_A),
    .rot_b     (ROT_B),
    .step_fwd  (step_fwd),
    .step_back (step_back)
  );

  always_comb begin
    state_d        = state_q;
    num1_d         = num1_q;
    num2_d         = num2_q;
    cin_d          = cin_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    case (state_q)
      S_IDLE, S_L1HI, S_L1LO, S_L2HI, S_L2LO, S_LCIN, S_SHOW: begin
        if (step_fwd) begin
          case (state_q)
            S_IDLE: begin
              num1_d  = '0;
              num2_d  = '0;
              cin_d   = 1'b0;
              state_d = S_L1HI;
            end
            S_L1HI: begin
              num1_d[6:4] = holder[2:0];
              state_d     = S_L1LO;
            end
            S_L1LO: begin
              num1_d[3:0] = holder;
              state_d     = S_L2HI;
            end
            S_L2HI: begin
              num2_d[6:4] = holder[2:0];
              state_d     = S_L2LO;
            end
            S_L2LO: begin
              num2_d[3:0] = holder;
              state_d     = S_LCIN;
            end
            S_LCIN: begin
              cin_d   = holder[0];
              state_d = S_SHOW;
            end
            default: state_d = S_IDLE;
          endcase
        end else if (step_back && state_q != S_IDLE) begin
          state_d = state_e'(state_q - 3'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture one cycle after entering SHOW so the adder sees the registered operands
    if (state_q == S_SHOW && !result_valid_q) begin
      result_d       = add_bus.sum_in;
      result_valid_d = 1'b1;
    end
    if (state_q == S_SHOW && (step_fwd || step_back)) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      num1_q         <= '0;
      num2_q         <= '0;
      cin_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      num1_q         <= num1_d;
      num2_q         <= num2_d;
      cin_q          <= cin_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign add_bus.num1 = num1_q;
  assign add_bus.num2 = num2_q;
  assign add_bus.cin  = cin_q;
  assign state        = state_q;
  assign result_valid = result_valid_q;
  assign led          = result_valid_q ? result_q : {5'b0, state_q};

endmodule

// File: tb/tb_rotary_entry_sequencer.sv
// Directed bench for the rotary entry sequencer with a behavioural adder on the operand bus.
module tb_rotary_entry_sequencer;
  import rotary_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       rot_a;
  logic       rot_b;
  logic [3:0] holder;
  logic [2:0] state;
  logic [7:0] result_q;
  logic       result_valid;
  logic [7:0] led;

  int n_cmp;
  int n_err;

  rotary_entry_sequencer_if bus ();

  // External adder: cin=1 inverts b and adds one (subtract)
  assign bus.sum_in = {1'b0, bus.num1} + {1'b0, bus.num2 ^ {7{bus.cin}}} + {7'b0, bus.cin};

  rotary_entry_sequencer #(.SYNC_STAGES(2), .FWD_DIR(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ROT_A        (rot_a),
    .ROT_B        (rot_b),
    .holder       (holder),
    .add_bus      (bus.master),
    .state        (state),
    .result_q     (result_q),
    .result_valid (result_valid),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // First half of a detent: leading phase, then 11 held for exactly 4 edges (step lands on the 4th)
  task automatic detent_head(input bit fwd);
    rot_a = ~fwd; rot_b = fwd;
    tick(4);
    rot_a = 1'b1; rot_b = 1'b1;
    tick(4);
  endtask

  task automatic detent_tail(input bit fwd);
    tick(2);
    rot_a = fwd; rot_b = ~fwd;
    tick(4);
    rot_a = 1'b0; rot_b = 1'b0;
    tick(4);
  endtask

  task automatic detent(input bit fwd, input logic [3:0] h);
    holder = h;
    detent_head(fwd);
    detent_tail(fwd);
  endtask

  task automatic test_reset;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (bus.num1 !== 7'h00) begin n_err++; $display("FAIL reset_num1: got %h want 00", bus.num1); end
    n_cmp++; if (bus.num2 !== 7'h00) begin n_err++; $display("FAIL reset_num2: got %h want 00", bus.num2); end
    n_cmp++; if (bus.cin !== 1'b0) begin n_err++; $display("FAIL reset_cin: got %b want 0", bus.cin); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL reset_led: got %h want 00", led); end
  endtask

  task automatic test_full_add;
    detent(1'b1, 4'hF);
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL add_state_l1hi: got %0d want 1", state); end
    n_cmp++; if (led !== 8'h01) begin n_err++; $display("FAIL add_led_state: got %h want 01", led); end
    detent(1'b1, 4'h5);
    detent(1'b1, 4'h3);
    n_cmp++; if (bus.num1 !== 7'h53) begin n_err++; $display("FAIL add_num1: got %h want 53", bus.num1); end
    detent(1'b1, 4'h2);
    detent(1'b1, 4'h7);
    n_cmp++; if (bus.num2 !== 7'h27) begin n_err++; $display("FAIL add_num2: got %h want 27", bus.num2); end
    holder = 4'h0;
    detent_head(1'b1);
    n_cmp++; if (state !== 3'd6) begin n_err++; $display("FAIL add_state_show: got %0d want 6", state); end
    n_cmp++; if (bus.cin !== 1'b0) begin n_err++; $display("FAIL add_cin: got %b want 0", bus.cin); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_early: got %b want 0", result_valid); end
    tick(1);
    n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", result_valid); end
    n_cmp++; if (result_q !== 8'h7A) begin n_err++; $display("FAIL add_result: got %h want 7a", result_q); end
    n_cmp++; if (led !== 8'h7A) begin n_err++; $display("FAIL add_led: got %h want 7a", led); end
    detent_tail(1'b1);
  endtask

  task automatic test_wrap;
    detent(1'b1, 4'h9);
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL wrap_state: got %0d want 0", state); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL wrap_valid: got %b want 0", result_valid); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL wrap_led: got %h want 00", led); end
    n_cmp++; if (result_q !== 8'h7A) begin n_err++; $display("FAIL wrap_result_kept: got %h want 7a", result_q); end
    n_cmp++; if (bus.num1 !== 7'h53) begin n_err++; $display("FAIL wrap_num1_kept: got %h want 53", bus.num1); end
    detent(1'b0, 4'h9);
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL back_in_idle: got %0d want 0", state); end
    detent(1'b1, 4'h9);
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL idle_step_state: got %0d want 1", state); end
    n_cmp++; if (bus.num1 !== 7'h00 || bus.num2 !== 7'h00) begin n_err++; $display("FAIL idle_step_clear: got %h/%h want 00/00", bus.num1, bus.num2); end
  endtask

  task automatic test_subtract;
    detent(1'b1, 4'h0);
    detent(1'b1, 4'h9);
    detent(1'b1, 4'h0);
    detent(1'b1, 4'h3);
    holder = 4'h1;
    detent_head(1'b1);
    n_cmp++; if (state !== 3'd6) begin n_err++; $display("FAIL sub_state_show: got %0d want 6", state); end
    n_cmp++; if (bus.num1 !== 7'h09 || bus.num2 !== 7'h03) begin n_err++; $display("FAIL sub_operands: got %h/%h want 09/03", bus.num1, bus.num2); end
    n_cmp++; if (bus.cin !== 1'b1) begin n_err++; $display("FAIL sub_cin: got %b want 1", bus.cin); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL sub_valid_early: got %b want 0", result_valid); end
    tick(1);
    n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid: got %b want 1", result_valid); end
    n_cmp++; if (result_q !== 8'h86) begin n_err++; $display("FAIL sub_result: got %h want 86", result_q); end
    detent_tail(1'b1);
    detent(1'b1, 4'h0);
    detent(1'b1, 4'h0);
  endtask

  task automatic test_back_step;
    detent(1'b1, 4'h1);
    detent(1'b1, 4'h4);
    n_cmp++; if (state !== 3'd3 || bus.num1 !== 7'h14) begin n_err++; $display("FAIL back_setup: got state %0d num1 %h want 3/14", state, bus.num1); end
    detent(1'b0, 4'hC);
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL back_state: got %0d want 2", state); end
    n_cmp++; if (bus.num1 !== 7'h14) begin n_err++; $display("FAIL back_num1_kept: got %h want 14", bus.num1); end
    detent(1'b1, 4'hA);
    n_cmp++; if (state !== 3'd3 || bus.num1 !== 7'h1A) begin n_err++; $display("FAIL back_reload: got state %0d num1 %h want 3/1a", state, bus.num1); end
  endtask

  task automatic test_chatter_latency;
    rot_a = 1'b0; rot_b = 1'b1;
    tick(4);
    rot_a = 1'b1; rot_b = 1'b1;
    tick(3);
    n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL latency_edge3: got %0d want 3", state); end
    tick(1);
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL latency_edge4: got %0d want 4", state); end
    for (int i = 0; i < 5; i++) begin
      rot_a = 1'b0; rot_b = 1'b1;
      tick(4);
      rot_a = 1'b1; rot_b = 1'b1;
      tick(4);
    end
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL chatter_single_step: got %0d want 4", state); end
    rot_a = 1'b0; rot_b = 1'b0;
    tick(4);
    detent(1'b1, 4'h0);
    n_cmp++; if (state !== 3'd5) begin n_err++; $display("FAIL chatter_rearm: got %0d want 5", state); end
  endtask

  task automatic test_illegal_state;
    detent(1'b1, 4'h0);
    detent(1'b1, 4'h0);
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL illegal_setup: got %0d want 0", state); end
    @(negedge clk);
    force dut.state_q = state_e'(3'd7);
    #1;
    n_cmp++; if (state !== 3'd7) begin n_err++; $display("FAIL illegal_forced: got %0d want 7", state); end
    release dut.state_q;
    tick(1);
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL illegal_recover: got %0d want 0", state); end
  endtask

  task automatic test_reset_mid_entry;
    detent(1'b1, 4'h0);
    detent(1'b1, 4'h3);
    detent(1'b1, 4'h5);
    detent(1'b1, 4'h2);
    n_cmp++; if (state !== 3'd4 || bus.num1 !== 7'h35) begin n_err++; $display("FAIL rst_setup: got state %0d num1 %h want 4/35", state, bus.num1); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (bus.num1 !== 7'h00 || bus.num2 !== 7'h00) begin n_err++; $display("FAIL rst_operands: got %h/%h want 00/00", bus.num1, bus.num2); end
    n_cmp++; if (bus.cin !== 1'b0) begin n_err++; $display("FAIL rst_cin: got %b want 0", bus.cin); end
    n_cmp++; if (result_q !== 8'h00) begin n_err++; $display("FAIL rst_result: got %h want 00", result_q); end
    n_cmp++; if (result_valid !== 1'b0 || led !== 8'h00) begin n_err++; $display("FAIL rst_valid_led: got %b/%h want 0/00", result_valid, led); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    detent(1'b1, 4'h0);
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL rst_resume: got %0d want 1", state); end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    rot_a  = 1'b0;
    rot_b  = 1'b0;
    holder = 4'h0;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(2);
    test_full_add();
    test_wrap();
    test_subtract();
    test_back_step();
    test_chatter_latency();
    test_illegal_state();
    test_reset_mid_entry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
